systolic_mac_pe: RTL and testbench

- Parametrised output-stationary processing element for the systolic matrix-multiply array in the CFU datapath.
- Per element: valid-qualified operand forwarding east/south, an input-offset (zero-point) correction on the west operand, and a wide accumulator with optional saturation.
- Adds a drain chain: after a tile, the column's accumulators shift out south through the PEs while the next tile starts accumulating.

---
 rtl/systolic_mac_pe.sv | 128 ++++++++++++
 tb/tb_systolic_mac_pe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: output-stationary MAC processing element.
// Forwards operands east/south and applies a zero-point offset to the west operand.
// Keeps a wide accumulator with optional saturation and a sticky overflow flag.
// A drain chain shifts the column's snapshots south while the next tile accumulates.
module systolic_mac_pe #(
  parameter int DATA_BITS = 8,
  parameter int ACC_BITS  = 32,
  parameter int SATURATE  = 1,
  parameter int ROW_IDX   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_BITS-1:0] inp_north,
  input  logic                        valid_north,
  input  logic signed [DATA_BITS-1:0] inp_west,
  input  logic                        valid_west,
  input  logic signed [DATA_BITS:0]   input_offset,
  input  logic                        acc_clear,
  input  logic                        drain,
  input  logic [ACC_BITS-1:0]         drain_in,
  input  logic                        drain_in_valid,
  output logic [DATA_BITS-1:0]        outp_south,
  output logic                        valid_south,
  output logic [DATA_BITS-1:0]        outp_east,
  output logic                        valid_east,
  output logic [ACC_BITS-1:0]         drain_out,
  output logic                        drain_out_valid,
  output logic [ACC_BITS-1:0]         result,
  output logic                        overflow,
  output logic                        busy
);

  localparam int A_BITS   = DATA_BITS + 2;
  localparam int P_BITS   = 2 * DATA_BITS + 2;
  localparam int CNT_BITS = (ROW_IDX > 0) ? $clog2(ROW_IDX + 1) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                      state;
  logic [CNT_BITS-1:0]         cnt;
  logic signed [ACC_BITS-1:0]  acc;
  logic signed [A_BITS-1:0]    a;
  logic signed [P_BITS-1:0]    p;
  logic signed [ACC_BITS-1:0]  pext;
  logic signed [ACC_BITS-1:0]  sum;
  logic signed [ACC_BITS-1:0]  acc_next;
  logic                        fire;
  logic                        accept;
  logic                        add_ovf;
  logic                        ovf_next;

  localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  // Datapath: offset-corrected product and next accumulator / overflow value.
  always_comb begin
    fire     = valid_north & valid_west;
    accept   = drain & (state == IDLE);
    a        = A_BITS'(inp_west) + A_BITS'(input_offset);
    p        = P_BITS'(a) * P_BITS'(inp_north);
    pext     = ACC_BITS'(p);
    sum      = acc + pext;
    add_ovf  = (acc[ACC_BITS-1] == pext[ACC_BITS-1]) &&
               (sum[ACC_BITS-1] != acc[ACC_BITS-1]);
    acc_next = acc;
    ovf_next = overflow;
    if (accept || acc_clear) begin
      // Restart never overflows: a single product always fits the accumulator.
      acc_next = fire ? pext : '0;
      ovf_next = 1'b0;
    end else if (fire) begin
      ovf_next = overflow | add_ovf;
      if (add_ovf && (SATURATE != 0))
        acc_next = acc[ACC_BITS-1] ? ACC_MIN : ACC_MAX;
      else
        acc_next = sum;
    end
  end

  // Registered forwarding, accumulator update and drain-chain state machine.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      acc             <= '0;
      overflow        <= 1'b0;
      outp_south      <= '0;
      valid_south     <= 1'b0;
      outp_east       <= '0;
      valid_east      <= 1'b0;
      drain_out       <= '0;
      drain_out_valid <= 1'b0;
    end else begin
      outp_south  <= inp_north;
      valid_south <= valid_north;
      outp_east   <= inp_west;
      valid_east  <= valid_west;
      acc         <= acc_next;
      overflow    <= ovf_next;
      case (state)
        IDLE: begin
          if (drain) begin
            drain_out       <= acc;
            drain_out_valid <= 1'b1;
            cnt             <= CNT_BITS'(ROW_IDX);
            state           <= (ROW_IDX > 0) ? DRAIN : IDLE;
          end else begin
            drain_out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          drain_out       <= drain_in;
          drain_out_valid <= drain_in_valid;
          if (drain_in_valid) begin
            cnt <= cnt - CNT_BITS'(1);
            if (cnt == CNT_BITS'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result = acc;
  assign busy   = (state == DRAIN);

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed testbench for systolic_mac_pe: single PE, saturating/wrapping
// 18-bit PEs, and a 3-deep drain column.
module tb_systolic_mac_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main PE (ACC 32, saturating, row 0) ----------------
  logic              rst, vn, vw, clr, drn, dinv;
  logic signed [7:0] n, w;
  logic signed [8:0] off;
  logic [31:0]       din;
  logic [7:0]        south, east;
  logic              vsouth, veast, dov, ovf, bsy;
  logic [31:0]       dout, res;

  systolic_mac_pe #(.DATA_BITS(8), .ACC_BITS(32), .SATURATE(1), .ROW_IDX(0)) u_dut (
    .clk(clk), .rst(rst), .inp_north(n), .valid_north(vn), .inp_west(w), .valid_west(vw),
    .input_offset(off), .acc_clear(clr), .drain(drn), .drain_in(din), .drain_in_valid(dinv),
    .outp_south(south), .valid_south(vsouth), .outp_east(east), .valid_east(veast),
    .drain_out(dout), .drain_out_valid(dov), .result(res), .overflow(ovf), .busy(bsy));

  // ---------------- saturating and wrapping PEs (ACC 18) ----------------
  logic              s_rst, s_v, s_clr;
  logic signed [7:0] s_n, s_w;
  logic [7:0]        sa_so, sa_eo, wr_so, wr_eo;
  logic              sa_vs, sa_ve, sa_dov, sa_ovf, sa_bsy;
  logic              wr_vs, wr_ve, wr_dov, wr_ovf, wr_bsy;
  logic [17:0]       sa_do, sa_res, wr_do, wr_res;

  systolic_mac_pe #(.DATA_BITS(8), .ACC_BITS(18), .SATURATE(1), .ROW_IDX(0)) u_sat (
    .clk(clk), .rst(s_rst), .inp_north(s_n), .valid_north(s_v), .inp_west(s_w), .valid_west(s_v),
    .input_offset(9'sd0), .acc_clear(s_clr), .drain(1'b0), .drain_in(18'd0), .drain_in_valid(1'b0),
    .outp_south(sa_so), .valid_south(sa_vs), .outp_east(sa_eo), .valid_east(sa_ve),
    .drain_out(sa_do), .drain_out_valid(sa_dov), .result(sa_res), .overflow(sa_ovf), .busy(sa_bsy));

  systolic_mac_pe #(.DATA_BITS(8), .ACC_BITS(18), .SATURATE(0), .ROW_IDX(0)) u_wrap (
    .clk(clk), .rst(s_rst), .inp_north(s_n), .valid_north(s_v), .inp_west(s_w), .valid_west(s_v),
    .input_offset(9'sd0), .acc_clear(s_clr), .drain(1'b0), .drain_in(18'd0), .drain_in_valid(1'b0),
    .outp_south(wr_so), .valid_south(wr_vs), .outp_east(wr_eo), .valid_east(wr_ve),
    .drain_out(wr_do), .drain_out_valid(wr_dov), .result(wr_res), .overflow(wr_ovf), .busy(wr_bsy));

  // ---------------- 3-PE drain column ----------------
  logic              c_rst, c_v, c_clr;
  logic signed [7:0] c_n;
  logic signed [7:0] c_w [3];
  logic              c_drn [3];
  logic [31:0]       c_do [3];
  logic              c_dov [3];
  logic [31:0]       c_res [3];
  logic              c_ovf [3];
  logic              c_bsy [3];
  logic [7:0]        c_so [3];
  logic [7:0]        c_eo [3];
  logic              c_vs [3];
  logic              c_ve [3];

  systolic_mac_pe #(.DATA_BITS(8), .ACC_BITS(32), .SATURATE(1), .ROW_IDX(0)) u_c0 (
    .clk(clk), .rst(c_rst), .inp_north(c_n), .valid_north(c_v), .inp_west(c_w[0]), .valid_west(c_v),
    .input_offset(9'sd0), .acc_clear(c_clr), .drain(c_drn[0]), .drain_in(32'd0), .drain_in_valid(1'b0),
    .outp_south(c_so[0]), .valid_south(c_vs[0]), .outp_east(c_eo[0]), .valid_east(c_ve[0]),
    .drain_out(c_do[0]), .drain_out_valid(c_dov[0]), .result(c_res[0]), .overflow(c_ovf[0]), .busy(c_bsy[0]));

  systolic_mac_pe #(.DATA_BITS(8), .ACC_BITS(32), .SATURATE(1), .ROW_IDX(1)) u_c1 (
    .clk(clk), .rst(c_rst), .inp_north(c_n), .valid_north(c_v), .inp_west(c_w[1]), .valid_west(c_v),
    .input_offset(9'sd0), .acc_clear(c_clr), .drain(c_drn[1]), .drain_in(c_do[0]), .drain_in_valid(c_dov[0]),
    .outp_south(c_so[1]), .valid_south(c_vs[1]), .outp_east(c_eo[1]), .valid_east(c_ve[1]),
    .drain_out(c_do[1]), .drain_out_valid(c_dov[1]), .result(c_res[1]), .overflow(c_ovf[1]), .busy(c_bsy[1]));

  systolic_mac_pe #(.DATA_BITS(8), .ACC_BITS(32), .SATURATE(1), .ROW_IDX(2)) u_c2 (
    .clk(clk), .rst(c_rst), .inp_north(c_n), .valid_north(c_v), .inp_west(c_w[2]), .valid_west(c_v),
    .input_offset(9'sd0), .acc_clear(c_clr), .drain(c_drn[2]), .drain_in(c_do[1]), .drain_in_valid(c_dov[1]),
    .outp_south(c_so[2]), .valid_south(c_vs[2]), .outp_east(c_eo[2]), .valid_east(c_ve[2]),
    .drain_out(c_do[2]), .drain_out_valid(c_dov[2]), .result(c_res[2]), .overflow(c_ovf[2]), .busy(c_bsy[2]));

  task automatic col_load();
    // one clear cycle with west = 10/20/30, north = 1 -> accumulators 10/20/30
    c_clr = 1'b1; c_v = 1'b1; c_n = 8'sd1;
    c_w[0] = 8'sd10; c_w[1] = 8'sd20; c_w[2] = 8'sd30;
    tick();
    c_clr = 1'b0; c_v = 1'b0;
  endtask

  task automatic col_all_drain(input logic d);
    for (int i = 0; i < 3; i++) c_drn[i] = d;
  endtask

  longint exp_sat, exp_wrap;

  initial begin
    rst = 1'b0; n = '0; vn = 1'b0; w = '0; vw = 1'b0; off = '0; clr = 1'b0; drn = 1'b0;
    din = '0; dinv = 1'b0;
    s_rst = 1'b0; s_v = 1'b0; s_clr = 1'b0; s_n = '0; s_w = '0;
    c_rst = 1'b0; c_v = 1'b0; c_clr = 1'b0; c_n = '0;
    for (int i = 0; i < 3; i++) begin c_w[i] = '0; c_drn[i] = 1'b0; end

    // ---- reset with random inputs ----
    for (int k = 0; k < 2; k++) begin
      n = 8'($urandom); w = 8'($urandom); vn = 1'($urandom); vw = 1'($urandom);
      off = 9'($urandom); clr = 1'($urandom); drn = 1'($urandom);
      din = $urandom; dinv = 1'($urandom);
      tick();
    end
    check("rst_result", longint'(res), 0);
    check("rst_outp_east", longint'(east), 0);
    check("rst_valid_south", longint'(vsouth), 0);
    check("rst_drain_out_valid", longint'(dov), 0);
    check("rst_drain_out", longint'(dout), 0);
    check("rst_overflow", longint'(ovf), 0);
    check("rst_busy", longint'(bsy), 0);

    // ---- release: east follows west by one cycle ----
    rst = 1'b1; clr = 1'b0; drn = 1'b0; dinv = 1'b0; vn = 1'b0; off = '0;
    w = 8'sd55; vw = 1'b0;
    tick();
    check("fwd_east_1", longint'(east), 55);
    w = 8'sd66;
    check("fwd_east_hold", longint'(east), 55);
    tick();
    check("fwd_east_2", longint'(east), 66);

    // ---- MAC, offset 0 ----
    clr = 1'b1; vn = 1'b0; vw = 1'b0;
    tick();
    check("clear_result", longint'($signed(res)), 0);
    clr = 1'b0; vn = 1'b1; vw = 1'b1;
    w = 8'sd3;  n = 8'sd4;  tick(); check("mac_1", longint'($signed(res)), 12);
    w = -8'sd2; n = 8'sd7;  tick(); check("mac_2", longint'($signed(res)), -2);
    w = 8'sd1;  n = -8'sd1; tick(); check("mac_3", longint'($signed(res)), -3);

    // ---- offset 128: (-100 + 128) * 5 = 140, restarted via acc_clear ----
    clr = 1'b1; off = 9'sd128; w = -8'sd100; n = 8'sd5;
    tick();
    check("offset_mac", longint'($signed(res)), 140);

    // ---- valid gating ----
    clr = 1'b0; off = '0; vw = 1'b0; vn = 1'b1; w = 8'sd9; n = 8'sd9;
    tick();
    check("gate_result", longint'($signed(res)), 140);
    check("gate_outp_east", longint'(east), 9);
    check("gate_valid_east", longint'(veast), 0);
    check("gate_valid_south", longint'(vsouth), 1);

    // ---- acc_clear together with a valid pair ----
    clr = 1'b1; vw = 1'b1; vn = 1'b1; w = 8'sd2; n = 8'sd3;
    tick();
    check("clear_pair", longint'($signed(res)), 6);

    // ---- drain on a row-0 PE: snapshot, clear, stays idle ----
    clr = 1'b0; vw = 1'b0; vn = 1'b0; drn = 1'b1;
    tick();
    check("drain0_out", longint'($signed(dout)), 6);
    check("drain0_valid", longint'(dov), 1);
    check("drain0_result", longint'($signed(res)), 0);
    check("drain0_busy", longint'(bsy), 0);
    drn = 1'b0;
    tick();
    check("drain0_valid_drop", longint'(dov), 0);
    check("drain0_out_hold", longint'($signed(dout)), 6);

    // ---- saturation vs wrap at ACC_BITS = 18 ----
    s_rst = 1'b1; s_clr = 1'b1;
    tick();
    s_clr = 1'b0; s_v = 1'b1; s_w = 8'sd127; s_n = 8'sd127;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_sat  = (k <= 8) ? longint'(k) * 16129 : 131071;
      exp_wrap = longint'(k) * 16129;
      if (exp_wrap > 131071) exp_wrap -= 262144;
      check($sformatf("sat_res_%0d", k), longint'($signed(sa_res)), exp_sat);
      check($sformatf("wrap_res_%0d", k), longint'($signed(wr_res)), exp_wrap);
      check($sformatf("sat_ovf_%0d", k), longint'(sa_ovf), (k >= 9) ? 1 : 0);
      check($sformatf("wrap_ovf_%0d", k), longint'(wr_ovf), (k >= 9) ? 1 : 0);
    end
    s_v = 1'b0; s_clr = 1'b1;
    tick();
    check("sat_clr_ovf", longint'(sa_ovf), 0);
    check("wrap_clr_ovf", longint'(wr_ovf), 0);
    check("sat_clr_res", longint'($signed(sa_res)), 0);
    s_clr = 1'b0;

    // ---- drain chain: 3-PE column holding 10/20/30 ----
    c_rst = 1'b1;
    col_load();
    check("col_load_bottom", longint'($signed(c_res[2])), 30);
    check("col_load_top", longint'($signed(c_res[0])), 10);
    // edge t: drain to all, pair (1,1)
    col_all_drain(1'b1); c_v = 1'b1; c_n = 8'sd1;
    for (int i = 0; i < 3; i++) c_w[i] = 8'sd1;
    tick();
    check("chain_t1_out", longint'($signed(c_do[2])), 30);
    check("chain_t1_valid", longint'(c_dov[2]), 1);
    check("chain_t1_busy", longint'(c_bsy[2]), 1);
    check("chain_t1_result", longint'($signed(c_res[2])), 1);
    // edge t+1: second drain to bottom only while busy -> ignored; pair (2,1)
    col_all_drain(1'b0); c_drn[2] = 1'b1;
    for (int i = 0; i < 3; i++) c_w[i] = 8'sd2;
    tick();
    check("chain_t2_out", longint'($signed(c_do[2])), 20);
    check("chain_t2_valid", longint'(c_dov[2]), 1);
    check("chain_t2_busy", longint'(c_bsy[2]), 1);
    check("chain_t2_result", longint'($signed(c_res[2])), 3);
    c_drn[2] = 1'b0;
    for (int i = 0; i < 3; i++) c_w[i] = 8'sd3;
    tick();
    check("chain_t3_out", longint'($signed(c_do[2])), 10);
    check("chain_t3_valid", longint'(c_dov[2]), 1);
    check("chain_t3_busy", longint'(c_bsy[2]), 0);
    check("chain_t3_result", longint'($signed(c_res[2])), 6);
    for (int i = 0; i < 3; i++) c_w[i] = 8'sd4;
    tick();
    check("chain_t4_valid", longint'(c_dov[2]), 0);
    check("chain_t4_result", longint'($signed(c_res[2])), 10);
    check("chain_t4_top_result", longint'($signed(c_res[0])), 10);
    c_v = 1'b0;

    // ---- reset in the middle of a drain ----
    col_load();
    col_all_drain(1'b1);
    tick();
    col_all_drain(1'b0);
    check("mid_busy_before", longint'(c_bsy[2]), 1);
    c_rst = 1'b0;
    tick();
    check("mid_rst_valid", longint'(c_dov[2]), 0);
    check("mid_rst_busy", longint'(c_bsy[2]), 0);
    check("mid_rst_result", longint'($signed(c_res[2])), 0);
    check("mid_rst_out", longint'($signed(c_do[2])), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
